// File: rtl/ysyx_22041207_me_lsu.sv
// ysyx_22041207_me_lsu: memory-stage LSU, one AXI4-Lite-style access per request; define YSYX_22041207_LSU_ALIGN_CHECK_EN to reject misaligned accesses
module ysyx_22041207_me_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic [7:0]  req_wmask,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [3:0]  read_num,
  input  logic        sext,
  output logic        me_wait_for_axi,
  output logic [63:0] rdata_o,
  output logic        done,
  output logic        bus_err,
  output logic        misalign,
  output logic        arvalid,
  input  logic        arready,
  output logic [63:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp
);
  typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} state_t;
  state_t state;
  logic [63:0] a_r, wd_r, sh, ld;
  logic [7:0]  wm_r;
  logic [3:0]  rn_r;
  logic        sx_r, err_r, mis_r, aw_ok, w_ok, req, mis;
  assign req = req_read | (|req_wmask);
`ifdef YSYX_22041207_LSU_ALIGN_CHECK_EN
  logic [3:0] sz;
  logic [2:0] lo;
  assign sz  = req_read ? read_num : 4'($countones(req_wmask));
  assign lo  = sz == 4'd1 ? 3'd0 : sz == 4'd2 ? 3'd1 : sz == 4'd4 ? 3'd3 : 3'd7;
  assign mis = |(addr[2:0] & lo);
`else
  assign mis = 1'b0;
`endif
  assign sh = rdata >> {a_r[2:0], 3'b000};
  always_comb
    ld = rn_r == 4'd1 ? {{56{sx_r & sh[7]}}, sh[7:0]} :
         rn_r == 4'd2 ? {{48{sx_r & sh[15]}}, sh[15:0]} :
         rn_r == 4'd4 ? {{32{sx_r & sh[31]}}, sh[31:0]} : sh;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      wd_r    <= '0;
      wm_r    <= '0;
      rn_r    <= '0;
      sx_r    <= 1'b0;
      rdata_o <= '0;
      err_r   <= 1'b0;
      mis_r   <= 1'b0;
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          a_r   <= addr;
          wd_r  <= wdata;
          wm_r  <= req_wmask;
          rn_r  <= read_num;
          sx_r  <= sext;
          aw_ok <= 1'b0;
          w_ok  <= 1'b0;
          err_r <= 1'b0;
          mis_r <= mis;
          state <= mis ? DONE : req_read ? AR : WR;
        end
        AR: if (arready) state <= R;
        R: if (rvalid) begin
          rdata_o <= ld;
          err_r   <= |rresp;
          state   <= DONE;
        end
        WR: begin
          aw_ok <= aw_ok | awready;
          w_ok  <= w_ok | wready;
          if ((aw_ok | awready) && (w_ok | wready)) state <= B;
        end
        B: if (bvalid) begin
          err_r <= |bresp;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign arvalid         = state == AR;
  assign rready          = state == R;
  assign awvalid         = state == WR && !aw_ok;
  assign wvalid          = state == WR && !w_ok;
  assign bready          = state == B;
  assign araddr          = {a_r[63:3], 3'b000};
  assign awaddr          = {a_r[63:3], 3'b000};
  assign wdata_o         = wd_r << {a_r[2:0], 3'b000};
  assign wstrb           = wm_r << a_r[2:0];
  assign done            = state == DONE;
  assign bus_err         = done & err_r;
  assign misalign        = done & mis_r;
  assign me_wait_for_axi = state == IDLE ? req : state != DONE;
endmodule

// File: tb/tb_ysyx_22041207_me_lsu.sv
// tb_ysyx_22041207_me_lsu: directed self-checking bench for the memory-stage LSU
module tb_ysyx_22041207_me_lsu;
  logic clk = 1'b0, rst = 1'b1;
  logic req_read = 1'b0, sext = 1'b0;
  logic [7:0] req_wmask = '0;
  logic [63:0] addr = '0, wdata = '0, rdata = '0;
  logic [3:0] read_num = '0;
  logic arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0] rresp = '0, bresp = '0;
  logic me_wait_for_axi, done, bus_err, misalign;
  logic arvalid, rready, awvalid, wvalid, bready;
  logic [63:0] rdata_o, araddr, awaddr, wdata_o;
  logic [7:0] wstrb;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ysyx_22041207_me_lsu dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_wmask(req_wmask), .addr(addr),
    .wdata(wdata), .read_num(read_num), .sext(sext), .me_wait_for_axi(me_wait_for_axi),
    .rdata_o(rdata_o), .done(done), .bus_err(bus_err), .misalign(misalign),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata_o(wdata_o), .wstrb(wstrb), .bvalid(bvalid),
    .bready(bready), .bresp(bresp)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_req();
    req_read = 1'b0;
    req_wmask = '0;
    addr = 64'hDEAD_BEEF_DEAD_BEE7;
    wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    read_num = 4'd1;
    sext = 1'b0;
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_wait", 64'(me_wait_for_axi), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_rdata_o", rdata_o, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    // load word, sign-extended, upper half of the bus
    addr = 64'h8000_0004; read_num = 4'd4; sext = 1'b1; req_read = 1'b1;
    arready = 1'b1; rvalid = 1'b1; rdata = 64'h8765_4321_0000_0000; rresp = 2'b00;
    #1;
    chk("ld_c0_wait", 64'(me_wait_for_axi), 64'd1);
    step();
    chk("ld_c1_arvalid", 64'(arvalid), 64'd1);
    chk("ld_c1_araddr", araddr, 64'h8000_0000);
    clr_req();
    step();
    chk("ld_c2_rready", 64'(rready), 64'd1);
    chk("ld_c2_wait", 64'(me_wait_for_axi), 64'd1);
    chk("ld_c2_done", 64'(done), 64'd0);
    step();
    chk("ld_c3_done", 64'(done), 64'd1);
    chk("ld_c3_rdata_o", rdata_o, 64'hFFFF_FFFF_8765_4321);
    chk("ld_c3_bus_err", 64'(bus_err), 64'd0);
    chk("ld_c3_wait", 64'(me_wait_for_axi), 64'd0);
    step();
    chk("ld_c4_done", 64'(done), 64'd0);
    // store byte at offset 3
    arready = 1'b0; rvalid = 1'b0;
    addr = 64'h8000_0003; req_wmask = 8'h01; wdata = 64'hAB;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    #1;
    chk("st_c0_wait", 64'(me_wait_for_axi), 64'd1);
    step();
    chk("st_c1_awvalid", 64'(awvalid), 64'd1);
    chk("st_c1_wvalid", 64'(wvalid), 64'd1);
    chk("st_c1_wstrb", 64'(wstrb), 64'h08);
    chk("st_c1_wdata_o", wdata_o, 64'hAB00_0000);
    chk("st_c1_awaddr", awaddr, 64'h8000_0000);
    clr_req();
    step();
    chk("st_c2_bready", 64'(bready), 64'd1);
    chk("st_c2_awvalid", 64'(awvalid), 64'd0);
    step();
    chk("st_c3_done", 64'(done), 64'd1);
    chk("st_c3_rdata_o_kept", rdata_o, 64'hFFFF_FFFF_8765_4321);
    step();
    // staggered AW/W handshake
    awready = 1'b1; wready = 1'b0; bvalid = 1'b0;
    addr = 64'h10; req_wmask = 8'hFF; wdata = 64'h1122_3344_5566_7788;
    step();
    chk("sg_c1_awvalid", 64'(awvalid), 64'd1);
    chk("sg_c1_wvalid", 64'(wvalid), 64'd1);
    clr_req();
    step();
    awready = 1'b0;
    chk("sg_c2_awvalid", 64'(awvalid), 64'd0);
    chk("sg_c2_wvalid", 64'(wvalid), 64'd1);
    chk("sg_c2_wait", 64'(me_wait_for_axi), 64'd1);
    step();
    chk("sg_c3_wvalid", 64'(wvalid), 64'd1);
    chk("sg_c3_bready", 64'(bready), 64'd0);
    step();
    wready = 1'b1;
    chk("sg_c4_wvalid", 64'(wvalid), 64'd1);
    chk("sg_c4_wdata_o", wdata_o, 64'h1122_3344_5566_7788);
    chk("sg_c4_wait", 64'(me_wait_for_axi), 64'd1);
    step();
    wready = 1'b0; bvalid = 1'b1;
    chk("sg_c5_bready", 64'(bready), 64'd1);
    chk("sg_c5_wvalid", 64'(wvalid), 64'd0);
    chk("sg_c5_wait", 64'(me_wait_for_axi), 64'd1);
    step();
    bvalid = 1'b0;
    chk("sg_c6_done", 64'(done), 64'd1);
    chk("sg_c6_bus_err", 64'(bus_err), 64'd0);
    step();
    // error load, halfword zero-extended; a simultaneous store mask is ignored
    addr = 64'h8; read_num = 4'd2; sext = 1'b0; req_read = 1'b1; req_wmask = 8'h0F;
    arready = 1'b1; rvalid = 1'b1; rdata = 64'h0000_0000_0000_F00D; rresp = 2'b10;
    step();
    chk("er_c1_arvalid", 64'(arvalid), 64'd1);
    chk("er_c1_awvalid", 64'(awvalid), 64'd0);
    clr_req();
    step();
    step();
    chk("er_c3_done", 64'(done), 64'd1);
    chk("er_c3_bus_err", 64'(bus_err), 64'd1);
    chk("er_c3_rdata_o", rdata_o, 64'h0000_0000_0000_F00D);
    step();
    rresp = 2'b00;
    chk("er_c4_bus_err", 64'(bus_err), 64'd0);
    // signed byte from lane 5
    addr = 64'h5; read_num = 4'd1; sext = 1'b1; req_read = 1'b1;
    rdata = 64'h0000_8000_0000_0000;
    step();
    clr_req();
    step();
    step();
    chk("sb_done", 64'(done), 64'd1);
    chk("sb_rdata_o", rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    step();
`ifdef YSYX_22041207_LSU_ALIGN_CHECK_EN
    arready = 1'b1;
    addr = 64'h8000_0002; read_num = 4'd4; sext = 1'b0; req_read = 1'b1;
    step();
    chk("ma_c1_done", 64'(done), 64'd1);
    chk("ma_c1_misalign", 64'(misalign), 64'd1);
    chk("ma_c1_arvalid", 64'(arvalid), 64'd0);
    chk("ma_c1_rdata_o_kept", rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    clr_req();
    step();
    chk("ma_c2_arvalid", 64'(arvalid), 64'd0);
    chk("ma_c2_misalign", 64'(misalign), 64'd0);
`else
    // misaligned word at offset 6: lanes past 7 are dropped
    addr = 64'h6; read_num = 4'd4; sext = 1'b1; req_read = 1'b1;
    rdata = 64'hC3C2_C1C0_0000_0000;
    step();
    chk("nc_ld_arvalid", 64'(arvalid), 64'd1);
    clr_req();
    step();
    step();
    chk("nc_ld_misalign", 64'(misalign), 64'd0);
    chk("nc_ld_rdata_o", rdata_o, 64'h0000_0000_0000_C3C2);
    step();
    addr = 64'h7; req_wmask = 8'h03; wdata = 64'hBEEF;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    step();
    chk("nc_st_wstrb", 64'(wstrb), 64'h80);
    chk("nc_st_wdata_o", wdata_o, 64'hEF00_0000_0000_0000);
    clr_req();
    step();
    step();
    chk("nc_st_done", 64'(done), 64'd1);
    step();
    bvalid = 1'b0;
`endif
    // reset in the middle of a read
    addr = 64'h0; read_num = 4'd8; req_read = 1'b1; arready = 1'b1; rvalid = 1'b0;
    step();
    clr_req();
    step();
    chk("rr_c2_rready", 64'(rready), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_rready", 64'(rready), 64'd0);
    chk("rr_arvalid", 64'(arvalid), 64'd0);
    chk("rr_wait", 64'(me_wait_for_axi), 64'd0);
    chk("rr_done", 64'(done), 64'd0);
    rvalid = 1'b1;
    step();
    chk("rr_next_done", 64'(done), 64'd0);
    chk("rr_next_rready", 64'(rready), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22041207_me_lsu.md
# ysyx_22041207_me_lsu

Memory-stage load/store unit. Consumes the access fields held in the EX/ME pipeline register (address, store data, byte mask, load size, sign-extend) and runs one AXI4-Lite-style transaction per access on a 64-bit data bus. While the access is in flight it drives `me_wait_for_axi` high so EX/ME and upstream stages hold. It returns aligned, extended load data to the write-back path.

## Interface
Parameters:
- none; bus is fixed at 64-bit address, 64-bit data, 8-bit strobe.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_read` in 1: load request (EX/ME `memoryReadWen_o`).
- `req_wmask` in 8: store byte mask, low-aligned (0x01/0x03/0x0F/0xFF); non-zero means store.
- `addr` in 64: byte address (EX/ME `aluRes_o`).
- `wdata` in 64: store data, low-aligned (EX/ME `rs2_o`).
- `read_num` in 4: load size in bytes (1/2/4/8).
- `sext` in 1: sign-extend load result.
- `me_wait_for_axi` out 1: stall to the pipeline.
- `rdata_o` out 64: extended load result, held until next load completes.
- `done` out 1: one-cycle pulse when access finishes.
- `bus_err` out 1: with `done`, RRESP/BRESP was non-zero.
- `misalign` out 1: with `done`, access rejected as misaligned (macro only; else tied 0).
- `arvalid` out 1, `arready` in 1, `araddr` out 64.
- `rvalid` in 1, `rready` out 1, `rdata` in 64, `rresp` in 2.
- `awvalid` out 1, `awready` in 1, `awaddr` out 64.
- `wvalid` out 1, `wready` in 1, `wdata_o` out 64, `wstrb` out 8.
- `bvalid` in 1, `bready` out 1, `bresp` in 2.

## Operation
- States: IDLE, AR, R, WR, B, DONE.
- IDLE:
  - `req_read` → AR.
  - else `req_wmask != 0` → WR.
  - Both set: treated as load; store ignored.
- AR: `arvalid=1`, `araddr={addr[63:3],3'b0}`. On `arready` → R.
- R: `rready=1`. On `rvalid`:
  - Take lanes `rdata >> (8*addr[2:0])`, truncate to `read_num` bytes.
  - Zero- or sign-extend per `sext`; register into `rdata_o`.
  - Capture `bus_err = |rresp`; → DONE.
- WR: `awvalid=1` and `wvalid=1` from the same cycle.
  - `awaddr` aligned as in AR.
  - `wdata_o = wdata << (8*addr[2:0])`.
  - `wstrb = (req_wmask << addr[2:0])[7:0]`.
  - Each valid drops independently after its own handshake. When both are done → B.
- B: `bready=1`. On `bvalid` capture `bus_err = |bresp` → DONE.
- DONE: `done=1` for one cycle; request inputs ignored; → IDLE.
- `me_wait_for_axi`, combinational:
  - High in IDLE when a request is present.
  - High in AR/R/WR/B.
  - Low in DONE and in idle-without-request.
  - The one-cycle DONE gap lets EX/ME load the next instruction before it is sampled.
- Address, data, mask, size, and sext are sampled into internal registers on leaving IDLE. Later input changes do not affect the in-flight access.
- Unsupported `read_num` (not 1/2/4/8) is treated as 8.

## Timing
- Reset values:
  - State IDLE.
  - All valid/ready outputs 0.
  - `rdata_o=0`, `done=0`, `bus_err=0`, `misalign=0`.
- `rst` mid-transaction: next cycle in IDLE with all valids low. No completion is reported. The outstanding bus transaction is abandoned.
- Load, zero-wait slave: request at cycle 0 (IDLE), AR at 1, R at 2, DONE at 3. `me_wait_for_axi` is high in cycles 0–2.
- Store, zero-wait slave: IDLE 0, WR 1, B 2, DONE 3.
- AW and W accepted in different cycles: stay in WR until the later one is accepted.
- `rdata_o` is valid from the DONE cycle onward.
- Stores leave `rdata_o` unchanged.

## Configuration
- `YSYX_22041207_LSU_ALIGN_CHECK_EN` defined:
  - Misalignment check: `addr % size != 0`. Size is `read_num` for loads and popcount(`req_wmask`) for stores.
  - A misaligned access goes IDLE→DONE with no bus activity.
  - DONE asserts `misalign=1`; `rdata_o` is unchanged.
- Not defined: no check.
  - The access is issued as computed.
  - Bytes shifted past lane 7 are dropped from `wstrb` and from load data.

## Test plan
- Load word, sext: `addr=0x8000_0004`, `read_num=4`, `sext=1`, slave `rdata=0x8765_4321_0000_0000`. Expect `araddr=0x8000_0000`, `rdata_o=0xFFFF_FFFF_8765_4321`, `done` in cycle 3.
- Store byte: `addr=0x8000_0003`, `req_wmask=0x01`, `wdata=0xAB`. Expect `wstrb=0x08`, `wdata_o=0xAB00_0000`, `awaddr=0x8000_0000`.
- Staggered handshake: `awready` at cycle 1, `wready` at cycle 4. Expect `awvalid` low from cycle 2, `wvalid` held to cycle 4, B entered at cycle 5, stall high throughout.
- Error response: load with `rresp=2'b10`. Expect `bus_err=1` with `done`, and `rdata_o` still updated.
- Reset mid-read: `rst` high during R. Next cycle `rready=0`, `me_wait_for_axi=0` with no request, and no `done`.
- Macro on: `addr=0x8000_0002`, `read_num=4`. Expect `misalign=1` in cycle 1, `arvalid` never asserted.
